vga_write_arbiter: RTL and testbench

Downstream stage of the game top level. Consumes the muxed pixel stream (x, y, colour, plot) and produces the single-port write interface of the VGA adapter. Runs a full-screen clear sweep on request. Pixel writes that arrive during the sweep are buffered in a small FIFO and drawn after the sweep finishes. The block guarantees at most one VGA write per cycle and never loses a sprite pixel silently.

---
 rtl/vga_write_arbiter_if.sv | 27 ++
 rtl/vga_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_vga_write_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_write_arbiter_if.sv
// Pixel-stream and VGA adapter write bus for vga_write_arbiter.
// The master drives the pixel stream and reads the adapter side; the slave is the arbiter.
interface vga_write_arbiter_if;
    logic [7:0] x_in;
    logic [7:0] y_in;
    logic [2:0] color_in;
    logic       plot_in;
    logic       clear_req;

    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_write;
    logic       clear_busy;
    logic       overflow;
    logic [2:0] fifo_count;

    modport master (
        output x_in, y_in, color_in, plot_in, clear_req,
        input  vga_x, vga_y, vga_colour, vga_write, clear_busy, overflow, fifo_count
    );

    modport slave (
        input  x_in, y_in, color_in, plot_in, clear_req,
        output vga_x, vga_y, vga_colour, vga_write, clear_busy, overflow, fifo_count
    );
endinterface

// File: rtl/vga_write_arbiter.sv
// Arbitrates the VGA adapter write port between a full-screen clear sweep and
// buffered sprite pixels. Plots arriving mid-sweep wait in a small FIFO.
module vga_write_arbiter #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         SCREEN_W   = 160,
    parameter int         SCREEN_H   = 120,
    parameter logic [2:0] BG_COLOR   = 3'b000
) (
    input logic                clk,
    input logic                reset_n,
    vga_write_arbiter_if.slave bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [7:0]    LAST_X  = 8'(SCREEN_W - 1);
    localparam logic [6:0]    LAST_Y  = 7'(SCREEN_H - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    sx_q, sx_d;
    logic [6:0]    sy_q, sy_d;
    logic [17:0]   mem_q [FIFO_DEPTH];
    logic [17:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    vga_x_q, vga_x_d;
    logic [6:0]    vga_y_q, vga_y_d;
    logic [2:0]    vga_colour_q, vga_colour_d;
    logic          vga_write_q, vga_write_d;
    logic          clear_busy_q, clear_busy_d;
    logic          overflow_q, overflow_d;

    logic in_range;
    logic push_valid;
    logic push;
    logic pop;
    logic step;

    // A clear request pre-empts both the sweep step and any pending pop on its edge,
    // so queued pixels stay in the FIFO until the new sweep has finished.
    always_comb begin
        state_d      = state_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        overflow_d   = overflow_q;

        in_range   = (bus.x_in <= LAST_X) && (bus.y_in <= {1'b0, LAST_Y});
        push_valid = bus.plot_in && in_range;
        pop        = (state_q == IDLE) && (count_q != '0) && !bus.clear_req;
        step       = (state_q == CLEAR) && !bus.clear_req;
        push       = push_valid && ((count_q != DEPTH_C) || pop);

        if (bus.clear_req) begin
            state_d = CLEAR;
            sx_d    = '0;
            sy_d    = '0;
        end else if (step) begin
            if (sx_q == LAST_X) begin
                sx_d = '0;
                if (sy_q == LAST_Y) begin
                    sy_d    = '0;
                    state_d = IDLE;
                end else begin
                    sy_d = sy_q + 7'd1;
                end
            end else begin
                sx_d = sx_q + 8'd1;
            end
        end

        vga_write_d = pop || step;
        if (pop) begin
            {vga_x_d, vga_y_d, vga_colour_d} = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else if (step) begin
            vga_x_d      = sx_q;
            vga_y_d      = sy_q;
            vga_colour_d = BG_COLOR;
        end

        // The full-FIFO slot is freed by a same-edge pop, so writing at wr_ptr is safe.
        if (push) begin
            mem_d[wr_ptr_q] = {bus.x_in, bus.y_in[6:0], bus.color_in};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push_valid && !push) begin
            overflow_d = 1'b1;
        end

        clear_busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sx_q         <= '0;
            sy_q         <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_write_q  <= 1'b0;
            clear_busy_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_write_q  <= vga_write_d;
            clear_busy_q <= clear_busy_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_write  = vga_write_q;
    assign bus.clear_busy = clear_busy_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = 3'(count_q);

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: queue/index reference model compared every cycle,
// directed scenarios with literal expectations, and a randomized plot phase.
module tb_vga_write_arbiter;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int D    = 4;
    localparam int NPIX = W * H;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    logic chk_en  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    vga_write_arbiter_if bus();

    vga_write_arbiter #(
        .FIFO_DEPTH(D),
        .SCREEN_W  (W),
        .SCREEN_H  (H),
        .BG_COLOR  (3'b000)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a pixel queue plus the index of the next sweep pixel (-1 when idle).
    logic [17:0] m_q[$];
    int          m_idx = -1;
    logic [7:0]  m_x   = '0;
    logic [6:0]  m_y   = '0;
    logic [2:0]  m_c   = '0;
    logic        m_wr  = 1'b0;
    logic        m_ovf = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0d, required %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic plot, input logic [7:0] x, input logic [7:0] y,
                                 input logic [2:0] c, input logic clr);
        @(negedge clk);
        bus.plot_in   = plot;
        bus.x_in      = x;
        bus.y_in      = y;
        bus.color_in  = c;
        bus.clear_req = clr;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_vga_x"},      int'(bus.vga_x), 0);
        checkOutput({tag, "_vga_y"},      int'(bus.vga_y), 0);
        checkOutput({tag, "_vga_colour"}, int'(bus.vga_colour), 0);
        checkOutput({tag, "_vga_write"},  int'(bus.vga_write), 0);
        checkOutput({tag, "_clear_busy"}, int'(bus.clear_busy), 0);
        checkOutput({tag, "_overflow"},   int'(bus.overflow), 0);
        checkOutput({tag, "_fifo_count"}, int'(bus.fifo_count), 0);
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_q.delete();
            m_idx = -1;
            m_x   = '0;
            m_y   = '0;
            m_c   = '0;
            m_wr  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            m_wr = 1'b0;
            if (bus.clear_req) begin
                m_idx = 0;
            end else if (m_idx >= 0) begin
                m_wr  = 1'b1;
                m_x   = 8'(m_idx % W);
                m_y   = 7'(m_idx / W);
                m_c   = 3'b000;
                m_idx = m_idx + 1;
                if (m_idx == NPIX) m_idx = -1;
            end else if (m_q.size() > 0) begin
                m_wr = 1'b1;
                {m_x, m_y, m_c} = m_q.pop_front();
            end
            if (bus.plot_in && int'(bus.x_in) < W && int'(bus.y_in) < H) begin
                if (m_q.size() < D) m_q.push_back({bus.x_in, bus.y_in[6:0], bus.color_in});
                else m_ovf = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            checkOutput("model_vga_write",  int'(bus.vga_write),  int'(m_wr));
            checkOutput("model_vga_x",      int'(bus.vga_x),      int'(m_x));
            checkOutput("model_vga_y",      int'(bus.vga_y),      int'(m_y));
            checkOutput("model_vga_colour", int'(bus.vga_colour), int'(m_c));
            checkOutput("model_clear_busy", int'(bus.clear_busy), (m_idx >= 0) ? 1 : 0);
            checkOutput("model_overflow",   int'(bus.overflow),   int'(m_ovf));
            checkOutput("model_fifo_count", int'(bus.fifo_count), m_q.size());
        end
    end

    int n_wr, first_i, last_i, busy_cnt, busy_first, bad_col, found;
    logic [7:0] px0, px160, pxl, qx;
    logic [6:0] py0, py160, pyl, qy;
    logic [2:0] qc;

    initial begin
        bus.plot_in   = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.color_in  = '0;
        bus.clear_req = 1'b0;

        // Test 1: reset, activity, asynchronous reset mid-activity
        #1 reset_n = 1'b0;
        #1 chk_en  = 1'b1;
        repeat (2) idleCycle();
        reset_n = 1'b1;
        checkAllZero("t1_reset");
        applyStimulus(1'b1, 8'd3, 8'd3, 3'd1, 1'b0);
        applyStimulus(1'b1, 8'd4, 8'd4, 3'd2, 1'b0);
        applyStimulus(1'b1, 8'd5, 8'd5, 3'd3, 1'b0);
        checkOutput("t1_pre_write", int'(bus.vga_write), 1);
        #2 reset_n = 1'b0;
        #1 checkAllZero("t1_async");
        idleCycle();
        idleCycle();
        reset_n = 1'b1;
        idleCycle();
        checkOutput("t1_post_busy",  int'(bus.clear_busy), 0);
        checkOutput("t1_post_count", int'(bus.fifo_count), 0);

        // Test 2: single plot latency
        applyStimulus(1'b1, 8'd10, 8'd20, 3'b100, 1'b0);
        idleCycle();
        checkOutput("t2_count1", int'(bus.fifo_count), 1);
        checkOutput("t2_write0", int'(bus.vga_write), 0);
        idleCycle();
        checkOutput("t2_write1", int'(bus.vga_write), 1);
        checkOutput("t2_x",      int'(bus.vga_x), 10);
        checkOutput("t2_y",      int'(bus.vga_y), 20);
        checkOutput("t2_colour", int'(bus.vga_colour), 4);
        checkOutput("t2_count0", int'(bus.fifo_count), 0);
        idleCycle();
        checkOutput("t2_write_end", int'(bus.vga_write), 0);

        // Test 5: out-of-range plots discarded, corner pixel accepted
        applyStimulus(1'b1, 8'd160, 8'd10, 3'd1, 1'b0);
        applyStimulus(1'b1, 8'd5, 8'd120, 3'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idleCycle();
            checkOutput("t5_write", int'(bus.vga_write), 0);
            checkOutput("t5_count", int'(bus.fifo_count), 0);
            checkOutput("t5_ovf",   int'(bus.overflow), 0);
        end
        applyStimulus(1'b1, 8'd159, 8'd119, 3'd5, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("t5_corner_write", int'(bus.vga_write), 1);
        checkOutput("t5_corner_x",     int'(bus.vga_x), 159);
        checkOutput("t5_corner_y",     int'(bus.vga_y), 119);
        checkOutput("t5_corner_c",     int'(bus.vga_colour), 5);

        // Test 3: full clear sweep
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        n_wr = 0; first_i = -1; last_i = -1; busy_cnt = 0; busy_first = -1; bad_col = 0;
        for (int i = 0; i < NPIX + 6; i++) begin
            idleCycle();
            if (bus.clear_busy) begin
                if (busy_first < 0) busy_first = i;
                busy_cnt++;
            end
            if (bus.vga_write) begin
                if (n_wr == 0) begin px0 = bus.vga_x; py0 = bus.vga_y; first_i = i; end
                if (n_wr == 160) begin px160 = bus.vga_x; py160 = bus.vga_y; end
                if (bus.vga_colour != 3'd0) bad_col++;
                pxl = bus.vga_x; pyl = bus.vga_y; last_i = i;
                n_wr++;
            end
        end
        checkOutput("t3_writes",     n_wr, NPIX);
        checkOutput("t3_first_i",    first_i, 1);
        checkOutput("t3_contiguous", last_i - first_i + 1, NPIX);
        checkOutput("t3_busy_cnt",   busy_cnt, NPIX);
        checkOutput("t3_busy_first", busy_first, 0);
        checkOutput("t3_bad_colour", bad_col, 0);
        checkOutput("t3_first_x",    int'(px0), 0);
        checkOutput("t3_first_y",    int'(py0), 0);
        checkOutput("t3_p160_x",     int'(px160), 0);
        checkOutput("t3_p160_y",     int'(py160), 1);
        checkOutput("t3_last_x",     int'(pxl), 159);
        checkOutput("t3_last_y",     int'(pyl), 119);

        // Test 4: plots during sweep, overflow, drain after sweep
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        repeat (3) idleCycle();
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 8'(i), 8'd7, 3'b010, 1'b0);
        idleCycle();
        checkOutput("t4_count_sat", int'(bus.fifo_count), 4);
        checkOutput("t4_overflow",  int'(bus.overflow), 1);
        found = 0;
        for (int i = 0; i < NPIX + 10 && found == 0; i++) begin
            idleCycle();
            if (bus.vga_write && bus.vga_x == 8'd159 && bus.vga_y == 7'd119) found = 1;
        end
        checkOutput("t4_sweep_end", found, 1);
        for (int i = 1; i <= 4; i++) begin
            idleCycle();
            checkOutput("t4_drain_write", int'(bus.vga_write), 1);
            checkOutput("t4_drain_x",     int'(bus.vga_x), i);
            checkOutput("t4_drain_y",     int'(bus.vga_y), 7);
            checkOutput("t4_drain_c",     int'(bus.vga_colour), 2);
        end
        idleCycle();
        checkOutput("t4_drain_done", int'(bus.vga_write), 0);
        checkOutput("t4_count_end",  int'(bus.fifo_count), 0);

        // Test 6a: clear beats pop, restart mid-sweep, queued pixel drains after
        reset_n = 1'b0;
        idleCycle();
        reset_n = 1'b1;
        applyStimulus(1'b1, 8'd9, 8'd9, 3'd7, 1'b0);
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        idleCycle();
        checkOutput("t6_clear_wins_write", int'(bus.vga_write), 0);
        checkOutput("t6_clear_wins_count", int'(bus.fifo_count), 1);
        checkOutput("t6_clear_wins_busy",  int'(bus.clear_busy), 1);
        n_wr = 0;
        for (int i = 0; i < 200 && n_wr < 50; i++) begin
            idleCycle();
            if (bus.vga_write) n_wr++;
        end
        checkOutput("t6_reach50", n_wr, 50);
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        n_wr = 0; first_i = -1; last_i = -1;
        for (int i = 0; i < NPIX + 20; i++) begin
            idleCycle();
            if (bus.vga_write) begin
                if (n_wr == 0) begin px0 = bus.vga_x; py0 = bus.vga_y; first_i = i; end
                if (n_wr == NPIX - 1) begin pxl = bus.vga_x; pyl = bus.vga_y; end
                if (n_wr == NPIX) begin qx = bus.vga_x; qy = bus.vga_y; qc = bus.vga_colour; end
                last_i = i;
                n_wr++;
            end
        end
        checkOutput("t6_restart_x",  int'(px0), 0);
        checkOutput("t6_restart_y",  int'(py0), 0);
        checkOutput("t6_restart_gap", first_i, 1);
        checkOutput("t6_writes",     n_wr, NPIX + 1);
        checkOutput("t6_contiguous", last_i - first_i + 1, NPIX + 1);
        checkOutput("t6_last_x",     int'(pxl), 159);
        checkOutput("t6_last_y",     int'(pyl), 119);
        checkOutput("t6_queued_x",   int'(qx), 9);
        checkOutput("t6_queued_y",   int'(qy), 9);
        checkOutput("t6_queued_c",   int'(qc), 7);

        // Test 6b: reset asserted at sweep pixel 1000
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        n_wr = 0;
        for (int i = 0; i < 1100 && n_wr < 1000; i++) begin
            idleCycle();
            if (bus.vga_write) n_wr++;
        end
        checkOutput("t6b_reach1000", n_wr, 1000);
        #2 reset_n = 1'b0;
        #1 checkAllZero("t6b_async");
        idleCycle();
        idleCycle();
        reset_n = 1'b1;
        n_wr = 0;
        for (int i = 0; i < 10; i++) begin
            idleCycle();
            if (bus.vga_write) n_wr++;
        end
        checkOutput("t6b_no_writes", n_wr, 0);
        checkOutput("t6b_busy",      int'(bus.clear_busy), 0);

        // Randomized phase: mixed in/out-of-range plots, then a sweep under plot pressure
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                          8'($urandom_range(0, 170)), 8'($urandom_range(0, 130)),
                          3'($urandom_range(0, 7)), 1'b0);
        end
        applyStimulus(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        for (int i = 0; i < NPIX + 300; i++) begin
            applyStimulus(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                          8'($urandom_range(0, 170)), 8'($urandom_range(0, 130)),
                          3'($urandom_range(0, 7)), 1'b0);
        end
        repeat (10) idleCycle();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
